// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions plus the GPIO register map.
package axi4l_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Register index taken from address bits [4:2]
  typedef enum logic [2:0] {
    REG_OUT      = 3'd0,
    REG_DIR      = 3'd1,
    REG_IN       = 3'd2,
    REG_SET      = 3'd3,
    REG_CLR      = 3'd4,
    REG_TGL      = 3'd5,
    REG_IRQ_EN   = 3'd6,
    REG_IRQ_STAT = 3'd7
  } reg_idx_t;

  localparam logic [4:0] OFS_OUT      = 5'h00;
  localparam logic [4:0] OFS_DIR      = 5'h04;
  localparam logic [4:0] OFS_IN       = 5'h08;
  localparam logic [4:0] OFS_SET      = 5'h0C;
  localparam logic [4:0] OFS_CLR      = 5'h10;
  localparam logic [4:0] OFS_TGL      = 5'h14;
  localparam logic [4:0] OFS_IRQ_EN   = 5'h18;
  localparam logic [4:0] OFS_IRQ_STAT = 5'h1C;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Expand byte strobes into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4l_gpio_sync.sv
// Multi-flop input synchroniser followed by a rising-edge detector.
module gpio_sync
  import axi4l_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [N-1:0] i_pins,
  output logic [N-1:0] o_in,
  output logic [N-1:0] o_rise
);

  logic [N-1:0] r_sync [SYNC_STAGES];
  logic [N-1:0] r_in_d;

  // Shift the raw pins through the synchroniser chain and keep a delayed copy of IN
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_in_d <= '0;
    end else begin
      r_sync[0] <= i_pins;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_in_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_in   = r_sync[SYNC_STAGES-1];
  assign o_rise = o_in & ~r_in_d;

endmodule

// File: rtl/axi4l_gpio.sv
// AXI4-Lite GPIO slave: direction, atomic set/clear/toggle, synchronised inputs, edge IRQs.
module axi4l_gpio
  import axi4l_pkg::*;
#(
  parameter int N           = 8,
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [N-1:0]      gpio_i,
  output logic [N-1:0]      gpio_o,
  output logic [N-1:0]      gpio_oe,
  output logic              irq
);

  wstate_t      r_wstate, w_wstate_nx;
  rstate_t      r_rstate, w_rstate_nx;
  logic [N-1:0] r_out, r_dir, r_irq_en, r_irq_stat;
  logic         r_irq;
  resp_t        r_bresp, r_rresp;
  logic [31:0]  r_rdata;

  logic [N-1:0] w_in, w_rise;
  logic         w_wr_hs, w_rd_hs;
  logic         w_wmapped, w_rmapped;
  reg_idx_t     w_widx, w_ridx;
  logic [31:0]  w_mask32;
  logic [N-1:0] w_mask, w_d, w_clr;
  logic [31:0]  w_rdata;
  logic         w_unused;

  gpio_sync #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .aclk   (aclk),
    .areset (areset),
    .i_pins (gpio_i),
    .o_in   (w_in),
    .o_rise (w_rise)
  );

  // Handshakes are suppressed during reset so nothing is accepted on a reset edge
  assign w_wr_hs   = (r_wstate == W_IDLE) && awvalid && wvalid && !areset;
  assign w_rd_hs   = (r_rstate == R_IDLE) && arvalid && !areset;
  assign w_wmapped = (awaddr[ADDR_W-1:5] == '0);
  assign w_rmapped = (araddr[ADDR_W-1:5] == '0);
  assign w_widx    = reg_idx_t'(awaddr[4:2]);
  assign w_ridx    = reg_idx_t'(araddr[4:2]);
  assign w_mask32  = strb_mask(wstrb);
  assign w_mask    = w_mask32[N-1:0];
  assign w_d       = wdata[N-1:0] & w_mask;
  assign w_clr     = (w_wr_hs && w_wmapped && w_widx == REG_IRQ_STAT) ? w_d : '0;

  // Protection bits, address byte offset and bits above N carry no meaning here
  assign w_unused = ^{awprot, arprot, awaddr, araddr, wdata, w_mask32};

  // Write channel state register
  always_ff @(posedge aclk) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nx;
  end

  // Write channel next state and ready strobes
  always_comb begin
    w_wstate_nx = r_wstate;
    awready     = 1'b0;
    wready      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_wr_hs) begin
          awready     = 1'b1;
          wready      = 1'b1;
          w_wstate_nx = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_wstate_nx = W_IDLE;
      end
      default: w_wstate_nx = W_IDLE;
    endcase
  end

  // Read channel state register
  always_ff @(posedge aclk) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nx;
  end

  // Read channel next state and ready strobe
  always_comb begin
    w_rstate_nx = r_rstate;
    arready     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_rd_hs) begin
          arready     = 1'b1;
          w_rstate_nx = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) w_rstate_nx = R_IDLE;
      end
      default: w_rstate_nx = R_IDLE;
    endcase
  end

  // Register file updates; edge-detected rises win over a same-cycle W1C
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out      <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      if (w_wr_hs) begin
        r_bresp <= w_wmapped ? RESP_OKAY : RESP_SLVERR;
        if (w_wmapped) begin
          case (w_widx)
            REG_OUT:    r_out    <= (r_out & ~w_mask) | w_d;
            REG_DIR:    r_dir    <= (r_dir & ~w_mask) | w_d;
            REG_SET:    r_out    <= r_out | w_d;
            REG_CLR:    r_out    <= r_out & ~w_d;
            REG_TGL:    r_out    <= r_out ^ w_d;
            REG_IRQ_EN: r_irq_en <= (r_irq_en & ~w_mask) | w_d;
            default: ;
          endcase
        end
      end
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_rise;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  // Read data mux; unmapped and write-only locations read as zero
  always_comb begin
    w_rdata = '0;
    if (w_rmapped) begin
      case (w_ridx)
        REG_OUT:      w_rdata[N-1:0] = r_out;
        REG_DIR:      w_rdata[N-1:0] = r_dir;
        REG_IN:       w_rdata[N-1:0] = w_in;
        REG_IRQ_EN:   w_rdata[N-1:0] = r_irq_en;
        REG_IRQ_STAT: w_rdata[N-1:0] = r_irq_stat;
        default: ;
      endcase
    end
  end

  // Capture read response at the address handshake and hold until accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_rd_hs) begin
      r_rdata <= w_rdata;
      r_rresp <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign bvalid  = (r_wstate == W_RESP);
  assign bresp   = r_bresp;
  assign rvalid  = (r_rstate == R_DATA);
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;
  assign gpio_o  = r_out;
  assign gpio_oe = r_dir;
  assign irq     = r_irq;

endmodule

// File: tb/tb_axi4l_gpio.sv
// Scoreboard bench for axi4l_gpio with a register-level reference model.
module tb_axi4l_gpio;

  localparam int N      = 8;
  localparam int ADDR_W = 12;
  localparam int SYNC   = 2;

  logic              aclk = 1'b0;
  logic              areset;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic              arvalid, arready, rvalid, rready;
  logic [N-1:0]      gpio_i, gpio_o, gpio_oe;
  logic              irq;

  always #5 aclk = ~aclk;

  axi4l_gpio #(.N(N), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  bq [$];
  rexp_t       rq [$];
  logic [1:0]  exp_b;
  rexp_t       exp_r;

  // Reference model state: one value per architectural register plus pin level
  logic [N-1:0] m_out, m_dir, m_en, m_stat, m_in;

  logic [11:0] t_a;
  int          t_op;
  int          t_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within 50 cycles at %0t", name, $time);
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic is_mapped(input logic [11:0] a);
    return a[11:5] == 7'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (is_mapped(a)) begin
      case (a[4:2])
        3'd0: v[N-1:0] = m_out;
        3'd1: v[N-1:0] = m_dir;
        3'd2: v[N-1:0] = m_in;
        3'd6: v[N-1:0] = m_en;
        3'd7: v[N-1:0] = m_stat;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] bm;
    logic [N-1:0] msk, nd;
    bm  = bytemask(s);
    msk = bm[N-1:0];
    nd  = d[N-1:0] & msk;
    if (is_mapped(a)) begin
      case (a[4:2])
        3'd0: m_out  = (m_out & ~msk) | nd;
        3'd1: m_dir  = (m_dir & ~msk) | nd;
        3'd3: m_out  = m_out | nd;
        3'd4: m_out  = m_out & ~nd;
        3'd5: m_out  = m_out ^ nd;
        3'd6: m_en   = (m_en & ~msk) | nd;
        3'd7: m_stat = m_stat & ~nd;
        default: ;
      endcase
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!(awready && wready) && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    if (n >= 50) begin
      timeout("aw_handshake");
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      bq.push_back(is_mapped(a) ? 2'b00 : 2'b10);
      model_write(a, d, s);
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check("gpio_o", {24'h0, gpio_o}, {24'h0, m_out});
      check("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
    end
  endtask

  task automatic axi_read(input logic [11:0] a);
    int n;
    n = 0;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    if (n >= 50) begin
      timeout("ar_handshake");
      arvalid = 1'b0;
    end else begin
      rq.push_back('{data: model_read(a), resp: (is_mapped(a) ? 2'b00 : 2'b10)});
      @(posedge aclk); #1;
      arvalid = 1'b0;
    end
  endtask

  // Drive a new pin pattern and hold it long enough to reach IRQ_STAT and irq
  task automatic set_pins(input logic [N-1:0] v);
    logic [N-1:0] rise;
    rise = v & ~m_in;
    @(negedge aclk);
    gpio_i = v;
    repeat (SYNC + 2) @(negedge aclk);
    m_stat = m_stat | rise;
    m_in   = v;
    check("irq_level", {31'h0, irq}, {31'h0, |(m_stat & m_en)});
  endtask

  // Monitor: pop and compare whenever a response is accepted
  always @(negedge aclk) begin
    if (!areset && bvalid && bready) begin
      if (bq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: bresp=%0d with empty queue at %0t", bresp, $time);
      end else begin
        exp_b = bq.pop_front();
        check("bresp", {30'h0, bresp}, {30'h0, exp_b});
      end
    end
    if (!areset && rvalid && rready) begin
      if (rq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL r_unexpected: rdata=0x%08h with empty queue at %0t", rdata, $time);
      end else begin
        exp_r = rq.pop_front();
        check("rdata", rdata, exp_r.data);
        check("rresp", {30'h0, rresp}, {30'h0, exp_r.resp});
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1; gpio_i = '0;
    m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_in = '0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Reset state
    check("rst_bvalid", {31'h0, bvalid}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_gpio_o", {24'h0, gpio_o}, 32'h0);
    for (int i = 0; i < 8; i++) axi_read(12'(i * 4));

    // OUT / SET / CLR / TGL
    axi_write(12'h000, 32'h0000_00A5, 4'hF); check("out_a5", {24'h0, gpio_o}, 32'hA5); axi_read(12'h000);
    axi_write(12'h00C, 32'h0000_000F, 4'hF); check("set_af", {24'h0, gpio_o}, 32'hAF); axi_read(12'h000);
    axi_write(12'h010, 32'h0000_0080, 4'hF); check("clr_2f", {24'h0, gpio_o}, 32'h2F); axi_read(12'h000);
    axi_write(12'h014, 32'h0000_0003, 4'hF); check("tgl_2c", {24'h0, gpio_o}, 32'h2C); axi_read(12'h000);

    // DIR with partial and empty strobes
    axi_write(12'h004, 32'hFFFF_FFFF, 4'b0001); check("dir_ff", {24'h0, gpio_oe}, 32'hFF); axi_read(12'h004);
    axi_write(12'h004, 32'h0000_0000, 4'b0000); check("dir_keep", {24'h0, gpio_oe}, 32'hFF); axi_read(12'h004);

    // Rising edge interrupt timing
    axi_write(12'h018, 32'h1, 4'hF);
    @(negedge aclk); gpio_i = 8'h01;
    repeat (SYNC + 1) @(posedge aclk); #1;
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    @(posedge aclk); #1;
    check("irq_set", {31'h0, irq}, 32'h1);
    m_stat = m_stat | 8'h01; m_in = 8'h01;
    axi_read(12'h01C);
    axi_read(12'h008);
    axi_write(12'h01C, 32'h1, 4'hF);
    repeat (2) @(negedge aclk);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    set_pins(8'h00);

    // W1C landing on the same edge as a new rise: the rise wins
    @(negedge aclk); gpio_i = 8'h01;
    @(negedge aclk);
    axi_write(12'h01C, 32'h1, 4'hF);
    m_stat = m_stat | 8'h01; m_in = 8'h01;
    repeat (2) @(negedge aclk);
    check("irq_collision", {31'h0, irq}, 32'h1);
    axi_read(12'h01C);
    axi_write(12'h01C, 32'h1, 4'h0);
    axi_read(12'h01C);

    // Unmapped address
    axi_write(12'h040, 32'hFF, 4'hF); check("unmapped_out", {24'h0, gpio_o}, 32'h2C);
    axi_read(12'h040);

    // Read and write completing together
    fork
      axi_write(12'h000, 32'h3C, 4'hF);
      axi_read(12'h004);
    join

    // Randomised traffic against the model
    for (int k = 0; k < 80; k++) begin
      t_op  = int'($urandom_range(0, 9));
      t_idx = int'($urandom_range(0, 7));
      t_a   = 12'(t_idx * 4);
      if ($urandom_range(0, 7) == 0) t_a[11:5] = 7'($urandom_range(1, 127));
      if (t_op < 5)      axi_write(t_a, $urandom, 4'($urandom));
      else if (t_op < 9) axi_read(t_a);
      else               set_pins(8'($urandom));
      repeat (2) @(negedge aclk);
      check("irq_rand", {31'h0, irq}, {31'h0, |(m_stat & m_en)});
    end
    set_pins(8'h00);
    repeat (4) @(negedge aclk);
    check("bq_drained", bq.size(), 32'h0);
    check("rq_drained", rq.size(), 32'h0);

    // Back-pressure, then reset while both responses are pending
    @(posedge aclk); #1; bready = 1'b0; rready = 1'b0;
    fork
      axi_write(12'h000, 32'h5A, 4'hF);
      axi_read(12'h004);
    join
    awaddr = 12'h00C; wdata = 32'hFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("hold_bvalid", {31'h0, bvalid}, 32'h1);
      check("hold_rvalid", {31'h0, rvalid}, 32'h1);
      check("hold_bresp", {30'h0, bresp}, {30'h0, bq[0]});
      check("hold_rresp", {30'h0, rresp}, {30'h0, rq[0].resp});
      check("hold_rdata", rdata, rq[0].data);
      check("hold_awready", {31'h0, awready}, 32'h0);
    end
    @(posedge aclk); #1; areset = 1'b1;
    @(posedge aclk); #1;
    check("rst_drop_bvalid", {31'h0, bvalid}, 32'h0);
    check("rst_drop_rvalid", {31'h0, rvalid}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    bq.delete(); rq.delete();
    m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_in = '0;
    @(posedge aclk); #1; areset = 1'b0; bready = 1'b1; rready = 1'b1;
    check("post_rst_gpio_o", {24'h0, gpio_o}, 32'h0);
    axi_read(12'h000);
    axi_write(12'h00C, 32'h81, 4'hF);
    axi_read(12'h000);
    repeat (4) @(negedge aclk);
    check("final_bq", bq.size(), 32'h0);
    check("final_rq", rq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
